// File: rtl/sign_ext_arbiter_if.sv
// Handshake bundle between the two extension requesters and the shared
// sign-extension arbiter: level requests with operands in, result and status out.
interface sign_ext_arbiter_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
);
  logic             req0;
  logic [IN_W-1:0]  imm0;
  logic             req1;
  logic [IN_W-1:0]  imm1;
  logic [OUT_W-1:0] out;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0, imm0, req1, imm1,
    input  out, done0, done1, busy, cnt0, cnt1
  );

  modport slave (
    input  req0, imm0, req1, imm1,
    output out, done0, done1, busy, cnt0, cnt1
  );
endinterface

// File: rtl/sign_ext_arbiter.sv
// Round-robin arbiter for the shared 9-to-16 sign extender: grants one of two
// requesters, registers the extended result, pulses done and counts services.
//
// state | meaning
// IDLE  | waiting; arbitrate and latch winner's operand
// EXT   | extend latched operand into out, raise winner's done
// RESP  | done visible; clear done, update round-robin pointer and counter
module sign_ext_arbiter #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_b,
  sign_ext_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, RESP = 2'd2} state_t;

  state_t           state;
  state_t           state_next;
  logic             grant;
  logic             win;
  logic             load_op;
  logic             fire;
  logic             finish;
  logic             busy_c;
  logic [IN_W-1:0]  op_reg;
  logic             gnt_id;
  logic             last_served;
  logic [OUT_W-1:0] out_r;
  logic             done0_r;
  logic             done1_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    win        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = 1'b1;
          win        = (bus.req0 && bus.req1) ? ~last_served : bus.req1;
          state_next = EXT;
        end
      end
      EXT:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_op = 1'b0;
    fire    = 1'b0;
    finish  = 1'b0;
    busy_c  = 1'b0;
    case (state)
      IDLE:    load_op = grant;
      EXT:     begin fire   = 1'b1; busy_c = 1'b1; end
      RESP:    begin finish = 1'b1; busy_c = 1'b1; end
      default: busy_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_reg      <= '0;
      gnt_id      <= 1'b0;
      last_served <= 1'b1;
      out_r       <= '0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      cnt0_r      <= '0;
      cnt1_r      <= '0;
    end else begin
      if (load_op) begin
        op_reg <= win ? bus.imm1 : bus.imm0;
        gnt_id <= win;
      end
      if (fire) begin
        out_r   <= {{(OUT_W-IN_W){op_reg[IN_W-1]}}, op_reg};
        done0_r <= ~gnt_id;
        done1_r <= gnt_id;
      end
      if (finish) begin
        done0_r     <= 1'b0;
        done1_r     <= 1'b0;
        last_served <= gnt_id;
        if (!gnt_id && cnt0_r != '1) cnt0_r <= cnt0_r + 1'b1;
        if (gnt_id && cnt1_r != '1)  cnt1_r <= cnt1_r + 1'b1;
      end
    end
  end

  assign bus.out   = out_r;
  assign bus.done0 = done0_r;
  assign bus.done1 = done1_r;
  assign bus.busy  = busy_c;
  assign bus.cnt0  = cnt0_r;
  assign bus.cnt1  = cnt1_r;

endmodule

// File: doc/sign_ext_arbiter.md
Name: sign_ext_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 9-to-16 sign-extension datapath in the calculator core. Requester 0 is the operand/immediate path and requester 1 is the jump-offset path. Each requester presents a narrow signed value. The block grants one requester at a time, feeds the value through the extender, registers the 16-bit result and returns a one-cycle done pulse. It also keeps a saturating service counter per requester for debug.

Parameters:
IN_W, 9, width of the signed input operand
OUT_W, 16, width of the extended result; must be >= IN_W
CNT_W, 8, width of each per-requester service counter

Ports:
clk  input  1  single system clock, rising-edge
rst_b  input  1  asynchronous, active-low reset
req0  input  1  request from requester 0; level, held until done0
imm0  input  IN_W  operand from requester 0; stable while req0 high
req1  input  1  request from requester 1; level, held until done1
imm1  input  IN_W  operand from requester 1; stable while req1 high
out  output  OUT_W  registered sign-extended result
done0  output  1  one-cycle pulse: out holds requester 0's result
done1  output  1  one-cycle pulse: out holds requester 1's result
busy  output  1  high whenever state != IDLE
cnt0  output  CNT_W  completed services for requester 0, saturating
cnt1  output  CNT_W  completed services for requester 1, saturating

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_b).
- Reset values: out=0, done0=done1=0, busy=0, cnt0=cnt1=0, state=IDLE, op_reg=0, gnt_id=0, last_served=1 (so requester 0 wins the first tie).
- FSM has three states: IDLE, EXT, RESP.
  - IDLE: if neither request is high, stay in IDLE. If only one is high, grant it. If both are high, grant the requester != last_served. On a grant: op_reg <= imm of the winner, gnt_id <= winner, go to EXT.
  - EXT: out <= {(OUT_W-IN_W){op_reg[IN_W-1]}, op_reg}; assert done[gnt_id] <= 1; go to RESP.
  - RESP: the done pulse is visible this cycle. Then: done <= 0, last_served <= gnt_id, cnt[gnt_id] += 1 (holds at all-ones), go to IDLE.
- Latency: a request sampled high in IDLE at cycle 0 gives done and a valid out in cycle 2. Each transaction occupies 3 cycles, so at most one result per 3 cycles.
- out holds its value between transactions. It changes only on the EXT→RESP edge.
- Handshake:
  - A requester must deassert req on the first edge after it sees done. Its req is then low when the FSM re-enters IDLE.
  - A req still high in IDLE is treated as a new request.
  - imm changes while the requester is not granted are don't-care. imm is sampled only in IDLE.
- Requests that arrive while busy wait. They are arbitrated in the next IDLE cycle, with no loss.
- Starvation-free: with both requesters continuously re-requesting, grants strictly alternate.
- Sign extension: bit IN_W-1 is replicated into out[OUT_W-1:IN_W]; lower bits are passed unchanged. No other arithmetic is performed.
- Counter saturation: a counter at 2^CNT_W-1 stays there. The other counter is unaffected.
- Reset mid-transaction (rst_b low in EXT or RESP): all state returns to reset values immediately. No done pulse is emitted for the aborted transaction, and cnt is not incremented.
- done0 and done1 are never high in the same cycle.

Test Plan:
- Reset, then req0=1, imm0=9'b101100110 in IDLE -> cycle 2: done0=1, out=16'hFF66, busy=1. Cycle 3: done0=0, cnt0=1.
- Single request req1=1, imm1=9'b001011110 -> done1 pulse in cycle 2, out=16'h005E, done0 stays 0, cnt1=1.
- After reset, req0 (imm0=9'h0FF) and req1 (imm1=9'h1FF) raised in the same cycle, each re-requesting after its done -> grants alternate: 0 (out=16'h00FF), then 1 (out=16'hFFFF), then 0, then 1.
- Requester 1 alone, three back-to-back requests with imm1=9'h100, 9'h101, 9'h000 -> out=16'hFF00, 16'hFF01, 16'h0000, exactly 3 cycles apart.
- rst_b pulsed low during EXT of a req0 transaction -> out=0, busy=0, cnt0=0, and no done0 pulse ever seen for that request.
- 260 consecutive req0 transactions -> cnt0 saturates at 8'hFF, cnt1 stays 0.
